// File: rtl/gray_to_rgb_axis.sv
// AXI-Stream gray-to-RGB expander with line/frame framing and a skid-buffered register slice.
// Optional build macro GRAY_FALSECOLOR_EN swaps {g,g,g} replication for a false-colour ramp.
module gray_to_rgb_axis #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_WIDTH  = 640,
  parameter int FRAME_LINES = 480,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [3*DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    m_tuser
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    s_tready_q;
  logic [3*DATA_WIDTH-1:0] out_rgb_q, out_rgb_d;
  logic                    out_last_q, out_last_d;
  logic                    out_user_q, out_user_d;
  logic [3*DATA_WIDTH-1:0] skid_rgb_q, skid_rgb_d;
  logic                    skid_last_q, skid_last_d;
  logic                    skid_user_q, skid_user_d;
  logic [CNT_WIDTH-1:0]    pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0]    line_cnt_q, line_cnt_d;

  logic                    accept;
  logic                    emit;
  logic [3*DATA_WIDTH-1:0] in_rgb;
  logic                    in_last;
  logic                    in_user;

  assign m_tvalid = (state_q != EMPTY);
  assign s_tready = s_tready_q;
  assign m_tdata  = out_rgb_q;
  assign m_tlast  = out_last_q;
  assign m_tuser  = out_user_q;

  assign accept = s_tvalid && s_tready_q;
  assign emit   = m_tvalid && m_tready;

`ifdef GRAY_FALSECOLOR_EN
  localparam logic [DATA_WIDTH-1:0] HALF = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAXV = {DATA_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] blue_lo;
  logic [DATA_WIDTH-1:0] red_hi;
  logic [DATA_WIDTH-1:0] green_hi;

  // Lower half ramps blue->green, upper half ramps green->red; each leg doubled to full scale.
  always_comb begin
    blue_lo  = (HALF - DATA_WIDTH'(1)) - s_tdata;
    red_hi   = s_tdata - HALF;
    green_hi = MAXV - s_tdata;
    if (s_tdata < HALF) begin
      in_rgb = {{DATA_WIDTH{1'b0}}, {s_tdata[DATA_WIDTH-2:0], 1'b0}, {blue_lo[DATA_WIDTH-2:0], 1'b0}};
    end else begin
      in_rgb = {{red_hi[DATA_WIDTH-2:0], 1'b0}, {green_hi[DATA_WIDTH-2:0], 1'b0}, {DATA_WIDTH{1'b0}}};
    end
  end
`else
  assign in_rgb = {s_tdata, s_tdata, s_tdata};
`endif

  assign in_last = (pix_cnt_q == CNT_WIDTH'(LINE_WIDTH - 1));
  assign in_user = (pix_cnt_q == '0) && (line_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    out_rgb_d   = out_rgb_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    skid_rgb_d  = skid_rgb_q;
    skid_last_d = skid_last_q;
    skid_user_d = skid_user_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_rgb_d  = in_rgb;
          out_last_d = in_last;
          out_user_d = in_user;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          out_rgb_d  = in_rgb;
          out_last_d = in_last;
          out_user_d = in_user;
        end else if (accept) begin
          skid_rgb_d  = in_rgb;
          skid_last_d = in_last;
          skid_user_d = in_user;
          state_d     = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      // s_tready is low in FULL, so only the drain path exists here.
      FULL: begin
        if (emit) begin
          out_rgb_d  = skid_rgb_q;
          out_last_d = skid_last_q;
          out_user_d = skid_user_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    if (accept) begin
      if (in_last) begin
        pix_cnt_d  = '0;
        line_cnt_d = (line_cnt_q == CNT_WIDTH'(FRAME_LINES - 1)) ? '0 : line_cnt_q + CNT_WIDTH'(1);
      end else begin
        pix_cnt_d = pix_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      s_tready_q  <= 1'b1;
      out_rgb_q   <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      skid_rgb_q  <= '0;
      skid_last_q <= 1'b0;
      skid_user_q <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_tready_q  <= (state_d != FULL);
      out_rgb_q   <= out_rgb_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      skid_rgb_q  <= skid_rgb_d;
      skid_last_q <= skid_last_d;
      skid_user_q <= skid_user_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

endmodule

// File: doc/gray_to_rgb_axis.md
# gray_to_rgb_axis

AXI-Stream pixel expander that turns the 8-bit grayscale stream back into a packed {R,G,B} stream for display and loop-back paths. It also frames the stream with per-line `m_tlast` and per-frame `m_tuser` (start-of-frame). It sits downstream of the grayscale output FIFO. Its master port drives the 3×DATA_WIDTH RGB slave interface of the RGB-to-gray pipeline or a video sink. Internally it is a full-throughput register slice with a skid buffer, so `s_tready` is a registered signal.

## Interface
- `DATA_WIDTH`, 8, bits per colour component and per gray pixel.
- `LINE_WIDTH`, 640, pixels per line; must be ≥ 2.
- `FRAME_LINES`, 480, lines per frame; must be ≥ 1.
- `CNT_WIDTH`, 10, width of the pixel and line counters; must satisfy 2^CNT_WIDTH ≥ max(LINE_WIDTH, FRAME_LINES).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_tdata`  in  DATA_WIDTH  gray pixel.
- `s_tvalid`  in  1  input pixel valid.
- `s_tready`  out  1  ready to accept; registered.
- `m_tdata`  out  3*DATA_WIDTH  {R,G,B}, with R in the MSBs.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  downstream ready.
- `m_tlast`  out  1  last pixel of a line.
- `m_tuser`  out  1  first pixel of a frame.

## Operation
- Accept: `s_tvalid && s_tready`. Emit: `m_tvalid && m_tready`.
- Two holding registers: OUT drives the `m_*` ports; SKID catches a beat accepted while OUT is stalled. Each register holds {rgb, last, user}.
- Three states:
  - EMPTY: OUT and SKID both invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: both valid.
- Transitions:
  - EMPTY, accept → ONE (the beat loads OUT).
  - ONE, accept and no emit → FULL (the beat loads SKID).
  - ONE, accept and emit → ONE (the beat loads OUT).
  - ONE, emit only → EMPTY.
  - FULL, emit → ONE (SKID moves into OUT).
  - FULL with no emit holds.
- `s_tready` = registered value of (next state ≠ FULL). Therefore no accept can occur in FULL.
- RGB expansion is combinational on `s_tdata` at accept time. The default is replication: {g,g,g}.
- Framing counters advance on accept only:
  - `pix_cnt` wraps from LINE_WIDTH-1 to 0.
  - `line_cnt` increments on the `pix_cnt` wrap, and wraps from FRAME_LINES-1 to 0.
- A beat's `last` = (`pix_cnt` == LINE_WIDTH-1) at accept time.
- A beat's `user` = (`pix_cnt` == 0 && `line_cnt` == 0) at accept time.
- Order is strictly preserved. No beat is dropped or duplicated under any `m_tready` pattern.

## Timing
- Reset values:
  - `m_tvalid` = 0, `m_tlast` = 0, `m_tuser` = 0, `m_tdata` = 0.
  - `s_tready` = 1; state = EMPTY; both counters = 0.
- Reset is asynchronous. Asserting `rst` mid-stream discards OUT, SKID and the counters immediately. The first beat accepted after release carries `m_tuser` = 1.
- Latency: a beat accepted on edge N is visible on `m_*` after edge N. It can be emitted on edge N+1 at the earliest.
- Throughput: 1 beat/cycle while `m_tready` = 1.
- Stall recovery: `s_tready` deasserts the cycle after SKID fills, and reasserts the cycle after SKID drains.
- Accept and emit on the same edge in ONE: OUT is replaced, with no bubble.
- `m_*` are stable while `m_tvalid && !m_tready`.
- `s_tdata` is ignored while `s_tvalid` = 0. `m_tdata` is don't-care while `m_tvalid` = 0, but must hold its last value (no toggling).

## Configuration
- `GRAY_FALSECOLOR_EN`: when defined, the replication mapping is replaced by a false-colour ramp. With H = 2^(DATA_WIDTH-1) and M = 2^DATA_WIDTH - 1:
  - g < H: R = 0, G = g<<1, B = (H-1-g)<<1.
  - g ≥ H: R = (g-H)<<1, G = (M-g)<<1, B = 0.
  - All results fit in DATA_WIDTH bits. The register structure, timing and framing are unchanged.
- When the macro is not defined: replication {g,g,g} only, and no ramp logic is synthesised.

## Test plan
- Reset then stream 0x00, 0x7F, 0xFF with `m_tready` = 1 → 0x000000, 0x7F7F7F, 0xFFFFFF, each one cycle after its accept, at 1 beat/cycle.
- With `m_tready` = 0, push 3 beats (0x10, 0x20, 0x30) → 2 are accepted and `s_tready` = 0 from the next cycle. Raise `m_tready` → 0x101010 then 0x202020, then `s_tready` = 1 and 0x30 flows through.
- Random `s_tvalid`/`m_tready` (50%), 10,000 beats, LINE_WIDTH = 4, FRAME_LINES = 3 → output equals the input in order. `m_tlast` is set on every 4th beat and `m_tuser` on beats 0, 12, 24, ….
- LINE_WIDTH = 4, FRAME_LINES = 2, send 8 beats → `m_tlast` on beats 3 and 7, and `m_tuser` on beat 0 only. Beat 8 carries `m_tuser` = 1.
- Assert `rst` while in FULL after 5 beats → `m_tvalid` = 0 and `s_tready` = 1 asynchronously. The next beat has `m_tuser` = 1.
- With `GRAY_FALSECOLOR_EN`: 0x00 → 0x0000FE, 0x7F → 0x00FE00, 0x80 → 0x00FE00, 0xFF → 0xFE0000.
